// File: rtl/acc_34.sv
// Multi-flux group accumulator: sums tagged 27-bit products in groups sized by a
// per-flux length token and emits one tagged signed 34-bit sum per group.
module acc_34 #(
    parameter int unsigned FLUX            = 2,
    parameter int unsigned DATA_WIDTH_PROD = 27,
    parameter int unsigned DATA_WIDTH_SIZE = 7,
    parameter int unsigned DATA_WIDTH_SUM  = DATA_WIDTH_PROD + DATA_WIDTH_SIZE,
    parameter int unsigned TAG_WIDTH       = $clog2(FLUX)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH_PROD+TAG_WIDTH-1:0] read_port_prod_dout_i,
    input  logic [FLUX-1:0]                     read_port_prod_empty_i,
    output logic [FLUX-1:0]                     read_port_prod_read_o,
    input  logic [DATA_WIDTH_SIZE+TAG_WIDTH-1:0] read_port_size_dout_i,
    input  logic [FLUX-1:0]                     read_port_size_empty_i,
    output logic [FLUX-1:0]                     read_port_size_read_o,
    output logic [DATA_WIDTH_SUM+TAG_WIDTH-1:0]  write_port_sum_din_o,
    input  logic [FLUX-1:0]                     write_port_sum_full_i,
    output logic [FLUX-1:0]                     write_port_sum_write_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    state_e                             state_q [FLUX];
    state_e                             state_d [FLUX];
    logic [DATA_WIDTH_SIZE-1:0]         len_q   [FLUX];
    logic [DATA_WIDTH_SIZE-1:0]         len_d   [FLUX];
    logic [DATA_WIDTH_SIZE-1:0]         cnt_q   [FLUX];
    logic [DATA_WIDTH_SIZE-1:0]         cnt_d   [FLUX];
    logic signed [DATA_WIDTH_SUM-1:0]   acc_q   [FLUX];
    logic signed [DATA_WIDTH_SUM-1:0]   acc_d   [FLUX];

    logic [FLUX-1:0]                    f1, f2, f3, elig, sel;
    logic [TAG_WIDTH-1:0]               tag;
    logic                               found;
    logic signed [DATA_WIDTH_SUM-1:0]   prod_ext;
    logic signed [DATA_WIDTH_SUM-1:0]   lane_sum;
    logic [DATA_WIDTH_SIZE-1:0]         size_data;
    logic [DATA_WIDTH_SIZE:0]           cnt_inc;
    logic                               unused_tags;

    // Incoming tag bits carry no information here; the output tag comes from arbitration.
    assign unused_tags = ^{read_port_prod_dout_i[DATA_WIDTH_PROD+TAG_WIDTH-1:DATA_WIDTH_PROD],
                           read_port_size_dout_i[DATA_WIDTH_SIZE+TAG_WIDTH-1:DATA_WIDTH_SIZE]};

    assign size_data = read_port_size_dout_i[DATA_WIDTH_SIZE-1:0];
    assign prod_ext  = {{(DATA_WIDTH_SUM-DATA_WIDTH_PROD){read_port_prod_dout_i[DATA_WIDTH_PROD-1]}},
                        read_port_prod_dout_i[DATA_WIDTH_PROD-1:0]};

    always_comb begin
        f1      = '0;
        f2      = '0;
        f3      = '0;
        cnt_inc = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            // cnt+1 compared against len in one extra bit avoids the len-1 wrap.
            cnt_inc = {1'b0, cnt_q[i]} + (DATA_WIDTH_SIZE+1)'(1);
            f1[i] = (state_q[i] == IDLE) && !read_port_size_empty_i[i];
            f2[i] = (state_q[i] == ACC) && !read_port_prod_empty_i[i]
                    && (cnt_inc < {1'b0, len_q[i]});
            f3[i] = (state_q[i] == ACC) && !read_port_prod_empty_i[i]
                    && (cnt_inc == {1'b0, len_q[i]}) && !write_port_sum_full_i[i];
        end
        elig = f1 | f2 | f3;
    end

    always_comb begin
        sel   = '0;
        tag   = '0;
        found = 1'b0;
        if (!rst) begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                if (!found && elig[i]) begin
                    sel[i] = 1'b1;
                    tag    = TAG_WIDTH'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        read_port_prod_read_o  = '0;
        read_port_size_read_o  = '0;
        write_port_sum_write_o = '0;
        write_port_sum_din_o   = '0;
        lane_sum               = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            state_d[i] = state_q[i];
            len_d[i]   = len_q[i];
            cnt_d[i]   = cnt_q[i];
            acc_d[i]   = acc_q[i];
            if (sel[i]) begin
                if (f1[i]) begin
                    read_port_size_read_o[i] = 1'b1;
                    len_d[i]   = size_data;
                    cnt_d[i]   = '0;
                    acc_d[i]   = '0;
                    state_d[i] = (size_data == '0) ? IDLE : ACC;
                end else begin
                    read_port_prod_read_o[i] = 1'b1;
                    lane_sum = acc_q[i] + prod_ext;
                    if (f3[i]) begin
                        write_port_sum_write_o[i] = 1'b1;
                        write_port_sum_din_o      = {tag, lane_sum};
                        state_d[i] = IDLE;
                        acc_d[i]   = '0;
                        cnt_d[i]   = '0;
                    end else begin
                        acc_d[i] = lane_sum;
                        cnt_d[i] = cnt_q[i] + DATA_WIDTH_SIZE'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                state_q[i] <= IDLE;
                len_q[i]   <= '0;
                cnt_q[i]   <= '0;
                acc_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                state_q[i] <= state_d[i];
                len_q[i]   <= len_d[i];
                cnt_q[i]   <= cnt_d[i];
                acc_q[i]   <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_acc_34.sv
// Directed bench for acc_34: FIFO lanes modelled as queues, sums checked
// against hand-computed constants.
module tb_acc_34;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] prod_dout;
    logic [1:0]  prod_empty, prod_read;
    logic [7:0]  size_dout;
    logic [1:0]  size_empty, size_read;
    logic [34:0] din;
    logic [1:0]  full, wr;

    always #5 clk = ~clk;

    acc_34 #(
        .FLUX(2),
        .DATA_WIDTH_PROD(27),
        .DATA_WIDTH_SIZE(7),
        .DATA_WIDTH_SUM(34),
        .TAG_WIDTH(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .read_port_prod_dout_i(prod_dout),
        .read_port_prod_empty_i(prod_empty),
        .read_port_prod_read_o(prod_read),
        .read_port_size_dout_i(size_dout),
        .read_port_size_empty_i(size_empty),
        .read_port_size_read_o(size_read),
        .write_port_sum_din_o(din),
        .write_port_sum_full_i(full),
        .write_port_sum_write_o(wr)
    );

    logic [26:0] pq0[$], pq1[$];
    logic [6:0]  sq0[$], sq1[$];
    longint      wr_data[$];
    int          wr_lane[$], wr_cyc[$];
    int          n_tests = 0, n_fail = 0, cyc = 0;
    logic [1:0]  last_prod_read;

    typedef struct {
        int     lane;
        int     len;
        int     p0, p1, p2, p3;
        longint exp;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: present FIFO state, answer reads with the lane head, observe, pop.
    task automatic step();
        int l;
        prod_empty = {pq1.size() == 0, pq0.size() == 0};
        size_empty = {sq1.size() == 0, sq0.size() == 0};
        #1;
        // Input tag bits are deliberately the inverse of the lane.
        if (prod_read[1] && !prod_read[0]) prod_dout = (pq1.size() > 0) ? {1'b0, pq1[0]} : '0;
        else                               prod_dout = (pq0.size() > 0) ? {1'b1, pq0[0]} : '0;
        if (size_read[1] && !size_read[0]) size_dout = (sq1.size() > 0) ? {1'b0, sq1[0]} : '0;
        else                               size_dout = (sq0.size() > 0) ? {1'b1, sq0[0]} : '0;
        #1;
        if (rst) chk("rst_quiet", longint'({prod_read, size_read, wr}), 0);
        chk("read_when_empty", longint'((prod_read & prod_empty) | (size_read & size_empty)), 0);
        if (wr != 2'b00) begin
            l = (wr[1] && !wr[0]) ? 1 : 0;
            chk("wr_onehot", $countones(wr), 1);
            chk("wr_with_read", longint'(prod_read[l]), 1);
            chk("wr_tag", longint'(din[34]), l);
            wr_data.push_back(longint'($signed(din[33:0])));
            wr_lane.push_back(l);
            wr_cyc.push_back(cyc);
        end else begin
            chk("din_idle_zero", longint'(din), 0);
        end
        last_prod_read = prod_read;
        if (prod_read[0] && pq0.size() > 0) void'(pq0.pop_front());
        if (prod_read[1] && pq1.size() > 0) void'(pq1.pop_front());
        if (size_read[0] && sq0.size() > 0) void'(sq0.pop_front());
        if (size_read[1] && sq1.size() > 0) void'(sq1.pop_front());
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int nwr, input int budget);
        int c = 0;
        while (wr_data.size() < nwr && c < budget) begin
            step();
            c++;
        end
        if (wr_data.size() < nwr) chk("timeout_waiting_write", wr_data.size(), nwr);
        step();
        step();
    endtask

    task automatic clear_wr();
        wr_data.delete();
        wr_lane.delete();
        wr_cyc.delete();
    endtask

    task automatic push_prod(input int lane, input int v);
        if (lane == 0) pq0.push_back(27'(v));
        else           pq1.push_back(27'(v));
    endtask

    task automatic push_size(input int lane, input int v);
        if (lane == 0) sq0.push_back(7'(v));
        else           sq1.push_back(7'(v));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        vt[0] = '{0, 4, 10, -3, 100, -7, 100};
        vt[1] = '{0, 1, -67108864, 0, 0, 0, -67108864};
        vt[2] = '{1, 3, -1000, 2000, -3000, 0, -2000};
        vt[3] = '{1, 1, 67108863, 0, 0, 0, 67108863};
        vt[4] = '{0, 2, -67108864, -67108864, 0, 0, -134217728};

        rst = 1'b1;
        full = 2'b00;
        prod_dout = '0;
        size_dout = '0;
        prod_empty = 2'b11;
        size_empty = 2'b11;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_outputs", longint'({prod_read, size_read, wr}), 0);
        chk("reset_no_write", wr_data.size(), 0);

        for (int v = 0; v < 5; v++) begin
            clear_wr();
            push_size(vt[v].lane, vt[v].len);
            if (vt[v].len > 0) push_prod(vt[v].lane, vt[v].p0);
            if (vt[v].len > 1) push_prod(vt[v].lane, vt[v].p1);
            if (vt[v].len > 2) push_prod(vt[v].lane, vt[v].p2);
            if (vt[v].len > 3) push_prod(vt[v].lane, vt[v].p3);
            run(1, 20);
            chk("vec_write_count", wr_data.size(), 1);
            if (wr_data.size() > 0) begin
                chk("vec_lane", wr_lane[0], vt[v].lane);
                chk("vec_data", wr_data[0], vt[v].exp);
            end
        end

        // Longest group at the positive extreme.
        clear_wr();
        push_size(0, 127);
        for (int k = 0; k < 127; k++) push_prod(0, 67108863);
        run(1, 200);
        chk("len127_count", wr_data.size(), 1);
        if (wr_data.size() > 0) chk("len127_data", wr_data[0], 64'd8522825601);

        // Output full at the last element: the final product waits.
        clear_wr();
        full = 2'b01;
        push_size(0, 3);
        push_prod(0, 7);
        push_prod(0, 8);
        push_prod(0, 9);
        step();
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_no_read", longint'(last_prod_read[0]), 0);
        end
        chk("stall_prod_left", pq0.size(), 1);
        chk("stall_no_write", wr_data.size(), 0);
        full = 2'b00;
        step();
        chk("stall_release_write", wr_data.size(), 1);
        if (wr_data.size() > 0) chk("stall_data", wr_data[0], 24);
        chk("stall_prod_drained", pq0.size(), 0);
        step();

        // Two lanes competing: lane 0 finishes first, lane 1 follows.
        clear_wr();
        push_size(0, 2);
        push_size(1, 2);
        push_prod(0, 1);
        push_prod(0, 2);
        push_prod(1, 5);
        push_prod(1, 6);
        base = cyc;
        run(2, 30);
        chk("ilv_count", wr_data.size(), 2);
        if (wr_data.size() == 2) begin
            chk("ilv_lane0", wr_lane[0], 0);
            chk("ilv_data0", wr_data[0], 3);
            chk("ilv_cyc0", wr_cyc[0] - base, 2);
            chk("ilv_lane1", wr_lane[1], 1);
            chk("ilv_data1", wr_data[1], 11);
            chk("ilv_cyc1", wr_cyc[1] - base, 5);
        end

        // Zero-length group is swallowed without a write.
        clear_wr();
        push_size(0, 0);
        push_size(0, 2);
        push_prod(0, 4);
        push_prod(0, 4);
        run(1, 20);
        chk("zero_len_count", wr_data.size(), 1);
        if (wr_data.size() > 0) chk("zero_len_data", wr_data[0], 8);
        chk("zero_len_sizes_used", sq0.size(), 0);

        // Reset in the middle of a group discards the partial sum.
        clear_wr();
        push_size(0, 4);
        push_prod(0, 5);
        push_prod(0, 5);
        for (int k = 0; k < 5; k++) step();
        chk("midrst_no_write_before", wr_data.size(), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_no_write_during", wr_data.size(), 0);
        push_size(0, 2);
        push_prod(0, 1);
        push_prod(0, 1);
        run(1, 20);
        chk("midrst_count", wr_data.size(), 1);
        if (wr_data.size() > 0) chk("midrst_data", wr_data[0], 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_34.md
Name: acc_34

Overview:
- Multi-flux HEVC dataflow actor that consumes the tagged 27-bit product token stream written by the 18x9 multiplier actor.
- Sums products in groups whose length comes from a per-group size token.
- Writes one tagged signed 34-bit sum per group.
- Sits directly downstream of the multiplier on the product FIFO. All fluxes share one datapath: at most one flux fires per cycle, chosen by fixed-priority arbitration.

Parameters:
- FLUX, 2, number of interleaved data fluxes (FIFO lanes).
- DATA_WIDTH_PROD, 27, signed product data width, excluding tag.
- DATA_WIDTH_SIZE, 7, unsigned group-length data width, excluding tag.
- DATA_WIDTH_SUM, 34, signed sum width (DATA_WIDTH_PROD + DATA_WIDTH_SIZE).
- TAG_WIDTH, $clog2(FLUX), flux tag width, prepended as MSBs of every token.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- read_port_prod  read_interface.actor  dout DATA_WIDTH_PROD+TAG_WIDTH, empty/read FLUX  product tokens.
- read_port_size  read_interface.actor  dout DATA_WIDTH_SIZE+TAG_WIDTH, empty/read FLUX  group-length tokens.
- write_port_sum  write_interface.actor  din DATA_WIDTH_SUM+TAG_WIDTH, full/write FLUX  sum tokens.

Behaviour:
- Per-flux registers:
  - state (IDLE=0, ACC=1)
  - len [6:0]
  - cnt [6:0]
  - acc signed [33:0]
- Reset (rst=1 at posedge): every flux goes to state=IDLE, len=0, cnt=0, acc=0. While rst=1, all read[i]=0 and write[i]=0 combinationally.
- Firing conditions for flux i:
  - F1: state=IDLE and size.empty[i]=0.
  - F2: state=ACC, prod.empty[i]=0, cnt<len-1.
  - F3: state=ACC, prod.empty[i]=0, cnt=len-1, sum.full[i]=0.
- Arbitration: tag = lowest i satisfying F1|F2|F3. If no flux is eligible, no read, no write, no register update.
- Only lane tag may see read/write=1; all other lanes are 0.
- Input tag bits (dout MSBs) are ignored. Output tag is always the arbitrated flux index.
- F1 action:
  - size.read[tag]=1.
  - len<=size.dout[6:0]; cnt<=0; acc<=0.
  - If size.dout[6:0]=0: stay IDLE and write nothing (token silently consumed). Otherwise go to ACC.
- F2 action:
  - prod.read[tag]=1.
  - acc<=acc+sext(prod.dout[26:0]); cnt<=cnt+1.
  - No write; sum.full is not checked.
- F3 action (last element):
  - prod.read[tag]=1 and sum.write[tag]=1 in the same cycle.
  - sum.din={tag, acc+sext(prod.dout[26:0])}.
  - Then state<=IDLE, acc<=0, cnt<=0.
- Stall: if sum.full[tag]=1 at the last element, the product token is not consumed and the flux stays blocked. Another flux may fire that cycle.
- Latency: the sum is written combinationally in the cycle the last product is read (0 cycles after the final read).
- din rule: sum.din = 0 whenever no write occurs.
- Arithmetic:
  - Two's complement, sign-extended to 34 bits.
  - Max magnitude 127*2^26 fits in 34 bits, so no overflow or saturation logic exists.
  - len=1: F3 fires on the first product; the sum is that product.
- Interleaving: per-flux state/cnt/acc are fully independent. A flux may be interrupted by higher-priority fluxes between any two of its tokens without corrupting its partial sum.
- Reset mid-group: partial sums are discarded and no partial sum is written. Tokens remaining in FIFOs after reset are the environment's problem.
- All register updates are addressed by tag and occur only at posedge clk with rst=0.

Test Plan:
1. Single flux, len=4, products 10,-3,100,-7 -> one write on lane 0, din data=100, tag=0, in the same cycle as the 4th read. Then state IDLE.
2. len=1, product -67108864 (min 27-bit) -> write data=34-bit sign-extended -67108864. Next, len=127 with all products 67108863 -> sum=8522825601, no overflow.
3. len=3, sum.full[0]=1 held 5 cycles before the last product -> 2 reads only, prod.read[0]=0 during the stall. Then full released -> write the sum in that cycle.
4. FLUX=2: both lanes have size and product tokens available continuously; lane 0 len=2 (1,2), lane 1 len=2 (5,6) -> lane 0 fires first. Lane 1 progresses only in cycles where lane 0 is blocked/idle. Outputs: lane 0 data=3 tag=0, lane 1 data=11 tag=1.
5. Size token 0, then size 2 with products 4,4 -> first token consumed with no write; then one write of data=8.
6. rst asserted after 2 of 4 products on lane 0 -> no write. After release, new len=2 with 1,1 -> sum=2, proving acc was cleared.
